// File: rtl/fetch_unit_pkg.sv
// Shared next-PC select encodings, reset PC default and branch offset helper
// for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ     = 3'b000,
    NPC_PRED    = 3'b001,
    NPC_RECOVER = 3'b010,
    NPC_J       = 3'b011,
    NPC_JR      = 3'b100
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Branch displacement: sign-extended word offset in bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls and imem data in, PC and IF/ID
// register contents out.
interface fetch_unit_if;
  logic        Stall;
  logic [2:0]  NextPCSignal;
  logic        IF_Flush;
  logic [31:0] Instr_IF;
  logic [31:0] JumpRegData_ID;
  logic [31:0] PC_IF;
  logic [5:0]  Opcode_IF;
  logic [31:0] PC_ID;
  logic [31:0] Instr_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic [31:0] RedirectCount;

  modport slave (
    input  Stall, NextPCSignal, IF_Flush, Instr_IF, JumpRegData_ID,
    output PC_IF, Opcode_IF, PC_ID, Instr_ID, PCPlus4_ID, Valid_ID, RedirectCount
  );

  modport master (
    output Stall, NextPCSignal, IF_Flush, Instr_IF, JumpRegData_ID,
    input  PC_IF, Opcode_IF, PC_ID, Instr_ID, PCPlus4_ID, Valid_ID, RedirectCount
  );
endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC mux and adders; also reports whether the effective
// select is a redirect.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [2:0]  i_sel,
  input  logic        i_valid_id,
  input  logic [31:0] i_pc_if,
  input  logic [15:0] i_imm_if,
  input  logic [31:0] i_pc_id,
  input  logic [25:0] i_jidx_id,
  input  logic [3:0]  i_pcp4_hi_id,
  input  logic [31:0] i_jr_data,
  output logic [31:0] o_npc,
  output logic        o_redirect
);

  npc_sel_e    w_eff;
  logic [31:0] w_pc_if_p4;

  assign w_pc_if_p4 = i_pc_if + 32'd4;

  // A squashed ID slot must never steer fetch, and reserved codes fall back
  // to sequential.
  always_comb begin
    w_eff = NPC_SEQ;
    case (i_sel)
      NPC_PRED:                   w_eff = NPC_PRED;
      NPC_RECOVER, NPC_J, NPC_JR: if (i_valid_id) w_eff = npc_sel_e'(i_sel);
      default:                    w_eff = NPC_SEQ;
    endcase
  end

  always_comb begin
    o_npc = w_pc_if_p4;
    case (w_eff)
      NPC_PRED:    o_npc = w_pc_if_p4 + br_offset(i_imm_if);
      NPC_RECOVER: o_npc = i_pc_id + 32'd4;
      NPC_J:       o_npc = {i_pcp4_hi_id, i_jidx_id, 2'b00};
      NPC_JR:      o_npc = i_jr_data;
      default:     o_npc = w_pc_if_p4;
    endcase
  end

  assign o_redirect = (w_eff != NPC_SEQ);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// saturating redirect counter; next-PC selection lives in npc_calc.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.slave  bus
);

  logic [31:0] r_pc_if;
  logic [31:0] r_pc_id;
  logic [31:0] r_instr_id;
  logic [31:0] r_pcp4_id;
  logic        r_valid_id;
  logic [31:0] r_redirect_cnt;

  logic [31:0] w_npc;
  logic        w_redirect;

  npc_calc u_npc (
    .i_sel        (bus.NextPCSignal),
    .i_valid_id   (r_valid_id),
    .i_pc_if      (r_pc_if),
    .i_imm_if     (bus.Instr_IF[15:0]),
    .i_pc_id      (r_pc_id),
    .i_jidx_id    (r_instr_id[25:0]),
    .i_pcp4_hi_id (r_pcp4_id[31:28]),
    .i_jr_data    (bus.JumpRegData_ID),
    .o_npc        (w_npc),
    .o_redirect   (w_redirect)
  );

  // Stall freezes the whole stage; flush only turns the IF/ID slot into a nop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_if        <= RESET_PC;
      r_pc_id        <= '0;
      r_instr_id     <= '0;
      r_pcp4_id      <= '0;
      r_valid_id     <= 1'b0;
      r_redirect_cnt <= '0;
    end else if (!bus.Stall) begin
      r_pc_if    <= w_npc;
      r_pc_id    <= r_pc_if;
      r_pcp4_id  <= r_pc_if + 32'd4;
      r_instr_id <= bus.IF_Flush ? 32'd0 : bus.Instr_IF;
      r_valid_id <= ~bus.IF_Flush;
      if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign bus.PC_IF         = r_pc_if;
  assign bus.Opcode_IF     = bus.Instr_IF[31:26];
  assign bus.PC_ID         = r_pc_id;
  assign bus.Instr_ID      = r_instr_id;
  assign bus.PCPlus4_ID    = r_pcp4_id;
  assign bus.Valid_ID      = r_valid_id;
  assign bus.RedirectCount = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: table of per-cycle stimulus with
// hand-computed IF/ID state, plus reset and branch corner sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        stall;
    logic [2:0]  sel;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_pcid;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_vld;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [15];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] pcid,
                           input logic [31:0] instr, input logic [31:0] p4,
                           input logic vld, input logic [31:0] cnt);
    chk({tag, " PC_IF"}, bus.PC_IF, pc);
    chk({tag, " PC_ID"}, bus.PC_ID, pcid);
    chk({tag, " Instr_ID"}, bus.Instr_ID, instr);
    chk({tag, " PCPlus4_ID"}, bus.PCPlus4_ID, p4);
    chk({tag, " Valid_ID"}, {31'd0, bus.Valid_ID}, {31'd0, vld});
    chk({tag, " RedirectCount"}, bus.RedirectCount, cnt);
  endtask

  task automatic drive(input logic st, input logic [2:0] sel, input logic fl,
                       input logic [31:0] instr, input logic [31:0] jr);
    bus.Stall          = st;
    bus.NextPCSignal   = sel;
    bus.IF_Flush       = fl;
    bus.Instr_IF       = instr;
    bus.JumpRegData_ID = jr;
  endtask

  initial begin
    //          st  sel     fl  instr          jr            PC_IF          PC_ID          Instr_ID       PCPlus4_ID     V  cnt
    vecs[0]  = '{0, 3'b000, 0, 32'h2000_0001, 32'h0,        32'h3004,      32'h3000,      32'h2000_0001, 32'h3004,      1, 0};
    vecs[1]  = '{0, 3'b000, 0, 32'h2000_0002, 32'h0,        32'h3008,      32'h3004,      32'h2000_0002, 32'h3008,      1, 0};
    vecs[2]  = '{0, 3'b000, 0, 32'h2000_0003, 32'h0,        32'h300C,      32'h3008,      32'h2000_0003, 32'h300C,      1, 0};
    vecs[3]  = '{0, 3'b000, 0, 32'h2000_0004, 32'h0,        32'h3010,      32'h300C,      32'h2000_0004, 32'h3010,      1, 0};
    vecs[4]  = '{0, 3'b001, 0, 32'h1000_0004, 32'h0,        32'h3024,      32'h3010,      32'h1000_0004, 32'h3014,      1, 1};
    vecs[5]  = '{0, 3'b010, 1, 32'h2000_0006, 32'h0,        32'h3014,      32'h3024,      32'h0,         32'h3028,      0, 2};
    vecs[6]  = '{0, 3'b100, 0, 32'h2000_0007, 32'h4000,     32'h3018,      32'h3014,      32'h2000_0007, 32'h3018,      1, 2};
    vecs[7]  = '{0, 3'b000, 0, 32'h2000_0008, 32'h0,        32'h301C,      32'h3018,      32'h2000_0008, 32'h301C,      1, 2};
    vecs[8]  = '{0, 3'b000, 0, 32'h0800_0C10, 32'h0,        32'h3020,      32'h301C,      32'h0800_0C10, 32'h3020,      1, 2};
    vecs[9]  = '{0, 3'b011, 1, 32'h2000_000A, 32'h0,        32'h3040,      32'h3020,      32'h0,         32'h3024,      0, 3};
    vecs[10] = '{0, 3'b000, 0, 32'h2000_000B, 32'h0,        32'h3044,      32'h3040,      32'h2000_000B, 32'h3044,      1, 3};
    vecs[11] = '{1, 3'b100, 1, 32'h2000_000C, 32'h4000,     32'h3044,      32'h3040,      32'h2000_000B, 32'h3044,      1, 3};
    vecs[12] = '{0, 3'b100, 0, 32'h2000_000D, 32'h4000,     32'h4000,      32'h3044,      32'h2000_000D, 32'h3048,      1, 4};
    vecs[13] = '{0, 3'b100, 0, 32'h2000_000E, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4000,      32'h2000_000E, 32'h4004,      1, 5};
    vecs[14] = '{0, 3'b000, 0, 32'h2000_000F, 32'h0,        32'h0,         32'hFFFF_FFFC, 32'h2000_000F, 32'h0,         1, 5};

    // Reset held two cycles with a redirect request pending.
    drive(0, 3'b011, 1, 32'h0800_0C10, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].stall, vecs[i].sel, vecs[i].flush, vecs[i].instr, vecs[i].jr);
      #1;
      chk($sformatf("v%0d Opcode_IF", i), {26'd0, bus.Opcode_IF}, {26'd0, vecs[i].instr[31:26]});
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_pcid, vecs[i].e_instr,
                vecs[i].e_p4, vecs[i].e_vld, vecs[i].e_cnt);
    end

    // Reset coinciding with a jump select: redirect discarded, counter cleared.
    drive(0, 3'b011, 0, 32'h0800_0C10, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_state("rst+jump", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // Jump select right after release targets a squashed slot: sequential.
    @(posedge clk);
    #1;
    chk_state("post-rst", 32'h3004, 32'h3000, 32'h0800_0C10, 32'h3004, 1'b1, 32'h0);

    // Predicted-taken branch with negative offset loops back onto itself.
    drive(0, 3'b001, 0, 32'h1000_FFFF, 32'h0);
    @(posedge clk);
    #1;
    chk_state("neg-br", 32'h3004, 32'h3004, 32'h1000_FFFF, 32'h3008, 1'b1, 32'h1);

    // Reserved select 111 behaves as sequential and does not count.
    drive(0, 3'b111, 0, 32'h2000_0010, 32'h0);
    @(posedge clk);
    #1;
    chk_state("rsvd-sel", 32'h3008, 32'h3004, 32'h2000_0010, 32'h3008, 1'b1, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
